rng_request_arbiter: RTL and testbench
======================================

// Module: rng_request_arbiter
// PURPOSE
//   Shares one RNG core between N_REQ requesters (card-dealing slots, etc.).
//   Picks one pending requester round-robin and issues a single-cycle request to the RNG.
//   Waits for the RNG to return valid data, then hands the word to the winner with a one-cycle ack.
//   A watchdog aborts the transaction if the RNG never answers.
// PARAMETERS
//   N_REQ    4   number of requesters (2..8)
//   DATA_W   8   RNG data width
//   TIMEOUT  15  max cycles spent in WAIT before abort (1..255)
// PORTS
//   clk_arb_i    in   1       system clock, rising edge
//   rst_arb_i    in   1       reset: synchronous, active-high
//   req_i        in   N_REQ   level request per requester; held until ack_o or timeout
//   gnt_o        out  N_REQ   one-hot current grant; zero when idle
//   rng_req_o    out  1       one-cycle request pulse to RNG core
//   rng_valid_i  in   1       RNG data valid (single-cycle strobe)
//   rng_data_i   in   DATA_W  RNG data, qualified by rng_valid_i
//   data_o       out  DATA_W  last delivered word; held until next delivery
//   ack_o        out  N_REQ   one-cycle pulse to the served requester; data_o valid that cycle
//   busy_o       out  1       high in any state other than IDLE
//   timeout_o    out  1       one-cycle pulse when a transaction is aborted
// BEHAVIOUR
//   Reset (rst_arb_i=1 at a rising edge, any state):
//     state=IDLE; gnt_o=0; ack_o=0; rng_req_o=0; data_o=0; timeout_o=0; busy_o=0; ptr=0; wait counter=0.
//     Reset overrides all other inputs in that cycle.
//     A transaction in flight is dropped silently: no ack_o, no timeout_o.
//   FSM, all outputs registered or decoded from the state register:
//   IDLE:
//     If req_i != 0: winner = first set bit scanning ptr, ptr+1, ... mod N_REQ.
//     gnt_o <= onehot(winner); go to ISSUE. Otherwise stay in IDLE.
//   ISSUE:
//     rng_req_o=1 for exactly this cycle; wait counter <= 0; go to WAIT.
//     rng_valid_i is ignored in ISSUE.
//   WAIT:
//     If rng_valid_i=1: data_o <= rng_data_i; go to ACK.
//     Else if counter == TIMEOUT-1: timeout_o pulses next cycle; ptr <= winner+1 mod N_REQ; gnt_o <= 0; go to IDLE.
//     Else counter increments.
//   ACK:
//     ack_o = gnt_o for this cycle; ptr <= winner+1 mod N_REQ; gnt_o <= 0; go to IDLE.
//   Latency and ordering:
//     Best case from req_i sampled at edge 0: rng_req_o high in cycle 1.
//     With valid in cycle 2, ack_o is high in cycle 3.
//     At least one IDLE cycle separates transactions.
//   Grant lifetime:
//     Grant is fixed for the whole transaction.
//     If the winner drops req_i mid-transaction, the transaction still completes and ack_o still pulses.
//     Requests from other sources arriving mid-transaction wait; they are not lost.
//   Round-robin rules:
//     After serving k, k gets lowest priority.
//     A requester that keeps req_i high is served again only after all other pending requesters.
//     ptr wraps from N_REQ-1 to 0.
//   Stray RNG strobes: rng_valid_i in IDLE, ISSUE or ACK is ignored; data_o is unchanged.
// TESTING
//   1. Single request: req_i=0001, RNG answers 0xA5 two cycles after rng_req_o
//      -> gnt_o=0001, exactly one rng_req_o pulse, ack_o=0001 one cycle, data_o=0xA5.
//   2. All requesters held high (req_i=1111), RNG answers at once
//      -> acks in order 0001,0010,0100,1000,0001; one rng_req_o per ack.
//   3. RNG never asserts valid, req_i=0100
//      -> timeout_o pulses TIMEOUT cycles after WAIT entry; no ack_o; gnt_o=0; next grant moves past requester 2.
//   4. rst_arb_i=1 during WAIT, then valid=1 the cycle after reset
//      -> all outputs 0, no ack_o, no timeout_o, ptr=0.
//   5. rng_valid_i pulsed in IDLE with data 0x3C
//      -> data_o unchanged, no ack_o.
//      Winner drops req_i in WAIT -> ack_o still pulses.
//   6. req_i=1010 after serving requester 3
//      -> next grant is 0010; after that 1000 (wrap-around check).

Source files
------------

// File: rtl/rng_request_arbiter_if.sv
// Bus between the RNG arbiter, its requesters and the shared RNG core.
// The slave modport is the arbiter itself. The master modport is the
// environment side: the requesters plus the RNG core.
interface rng_request_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]  req_i;
    logic [N_REQ-1:0]  gnt_o;
    logic              rng_req_o;
    logic              rng_valid_i;
    logic [DATA_W-1:0] rng_data_i;
    logic [DATA_W-1:0] data_o;
    logic [N_REQ-1:0]  ack_o;
    logic              busy_o;
    logic              timeout_o;

    modport slave (
        input  req_i, rng_valid_i, rng_data_i,
        output gnt_o, rng_req_o, data_o, ack_o, busy_o, timeout_o
    );

    modport master (
        output req_i, rng_valid_i, rng_data_i,
        input  gnt_o, rng_req_o, data_o, ack_o, busy_o, timeout_o
    );
endinterface

// File: rtl/rng_request_arbiter.sv
// Round-robin arbiter that shares one RNG core between N_REQ requesters.
// Each transaction follows the sequence IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
// A watchdog in WAIT aborts the transaction back to IDLE when the RNG
// does not answer in time.
module rng_request_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input logic                   clk_arb_i,
    input logic                   rst_arb_i,
    rng_request_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  pick;
    logic              pick_vld;
    logic [PTR_W-1:0]  ptr_inc;
    logic [CNT_W-1:0]  cnt;
    logic [N_REQ-1:0]  gnt;
    logic [DATA_W-1:0] data;
    logic              timeout;

    // Round-robin pick: the first pending request found when scanning from ptr
    // upward with wrap-around. The scan runs from the farthest offset down to
    // the nearest, so the nearest pending request is the one that sticks.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (bus.req_i[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // The slot after the winner gets top priority next time, so the winner
    // drops to the lowest priority.
    assign ptr_inc = (winner == PTR_MAX) ? '0 : winner + 1'b1;

    // State register
    always_ff @(posedge clk_arb_i) begin
        if (rst_arb_i) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (bus.rng_valid_i)    state_nxt = ACK;
                else if (cnt == CNT_LAST) state_nxt = IDLE;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered datapath: the grant, the pointer, the watchdog counter,
    // the delivered word and the abort pulse.
    // A reset drops an in-flight transaction without any ack or abort pulse.
    always_ff @(posedge clk_arb_i) begin
        if (rst_arb_i) begin
            ptr     <= '0;
            winner  <= '0;
            cnt     <= '0;
            gnt     <= '0;
            data    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        winner <= pick;
                        gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (bus.rng_valid_i) begin
                        data <= bus.rng_data_i;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        ptr     <= ptr_inc;
                        gnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    ptr <= ptr_inc;
                    gnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the state register. The registered ones pass straight through.
    always_comb begin
        bus.rng_req_o = (state == ISSUE);
        bus.ack_o     = (state == ACK) ? gnt : '0;
        bus.busy_o    = (state != IDLE);
        bus.gnt_o     = gnt;
        bus.data_o    = data;
        bus.timeout_o = timeout;
    end
endmodule

// File: tb/tb_rng_request_arbiter.sv
// Scoreboard bench for rng_request_arbiter. An expected {ack, data} pair is
// queued each time an RNG answer is driven. The pair is popped and compared
// whenever the DUT pulses ack_o.
module tb_rng_request_arbiter;
    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [N_REQ-1:0]  ack;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rng_request_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    rng_request_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_arb_i (clk),
        .rst_arb_i (rst),
        .bus       (bus)
    );

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                n_rng_req = 0;
    int                n_timeout = 0;
    int                n_ack = 0;
    logic [DATA_W-1:0] last_word = '0;

    // Advance one cycle, sample 1ns after the edge, and drain ack_o against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.rng_req_o) n_rng_req++;
        if (bus.timeout_o) n_timeout++;
        if (bus.ack_o != '0) begin
            n_ack++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack ack=%b data=%h", bus.ack_o, bus.data_o);
            end else begin
                e = sb.pop_front();
                if (bus.ack_o !== e.ack || bus.data_o !== e.data) begin
                    errors++;
                    $display("FAIL sb_ack got ack=%b data=%h want ack=%b data=%h",
                             bus.ack_o, bus.data_o, e.ack, e.data);
                end
            end
        end
    endtask

    // Wait (bounded) for the rng_req_o pulse, then check the grant and queue the expected result.
    // After d cycles in WAIT, answer with word. Return in the ACK cycle.
    task automatic serve(input logic [N_REQ-1:0] exp_gnt, input logic [DATA_W-1:0] word,
                         input int d, input bit drop);
        exp_t e;
        int   w;
        w = 0;
        while (!bus.rng_req_o && w < 20) begin
            step();
            w++;
        end
        checks++;
        if (!bus.rng_req_o) begin
            errors++;
            $display("FAIL rng_req_wait no rng_req_o within 20 cycles want gnt=%b", exp_gnt);
            return;
        end
        checks++;
        if (bus.gnt_o !== exp_gnt) begin
            errors++;
            $display("FAIL issue_gnt got %b want %b", bus.gnt_o, exp_gnt);
        end
        e.ack  = exp_gnt;
        e.data = word;
        sb.push_back(e);
        for (int k = 0; k < d; k++) begin
            step();
            if (drop && k == 0) bus.req_i = '0;
        end
        bus.rng_valid_i = 1'b1;
        bus.rng_data_i  = word;
        step();
        bus.rng_valid_i = 1'b0;
        bus.rng_data_i  = DATA_W'($urandom);
        last_word = word;
    endtask

    // Reset with every requester pending: every output must be held at zero.
    task automatic test_reset();
        rst        = 1'b1;
        bus.req_i  = '1;
        repeat (3) step();
        checks++;
        if ({bus.gnt_o, bus.ack_o, bus.rng_req_o, bus.busy_o, bus.timeout_o, bus.data_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b ack=%b rng_req=%b busy=%b timeout=%b data=%h want all 0",
                     bus.gnt_o, bus.ack_o, bus.rng_req_o, bus.busy_o, bus.timeout_o, bus.data_o);
        end
        bus.req_i = '0;
        rst       = 1'b0;
        step();
    endtask

    // All four requesters held high: grants rotate 0, 1, 2, 3, 0 with one rng_req_o per ack.
    task automatic test_round_robin();
        int r0, a0;
        logic [N_REQ-1:0] oh;
        r0 = n_rng_req;
        a0 = n_ack;
        bus.req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            serve(oh, DATA_W'(8'h10 + k), 1, 1'b0);
        end
        bus.req_i = '0;
        step();
        checks++;
        if (n_rng_req - r0 != 5 || n_ack - a0 != 5) begin
            errors++;
            $display("FAIL rr_counts got rng_req=%0d ack=%0d want 5 and 5", n_rng_req - r0, n_ack - a0);
        end
    endtask

    // A single request: rng_req_o comes one cycle after req_i, the RNG answers two cycles later,
    // and an IDLE cycle follows the ack.
    task automatic test_single();
        int r0;
        r0 = n_rng_req;
        bus.req_i = 4'b0001;
        step();
        checks++;
        if (bus.rng_req_o !== 1'b1) begin
            errors++;
            $display("FAIL single_latency rng_req_o got %b want 1", bus.rng_req_o);
        end
        serve(4'b0001, 8'hA5, 2, 1'b0);
        bus.req_i = '0;
        step();
        checks++;
        if (bus.busy_o !== 1'b0 || bus.gnt_o !== '0 || bus.data_o !== 8'hA5) begin
            errors++;
            $display("FAIL single_after busy=%b gnt=%b data=%h want 0 0 a5", bus.busy_o, bus.gnt_o, bus.data_o);
        end
        checks++;
        if (n_rng_req - r0 != 1) begin
            errors++;
            $display("FAIL single_rng_req_count got %0d want 1", n_rng_req - r0);
        end
    endtask

    // The RNG never answers: the transaction aborts TIMEOUT cycles after WAIT entry, with no ack.
    task automatic test_timeout();
        int t0, a0, w;
        t0 = n_timeout;
        a0 = n_ack;
        w  = 0;
        bus.req_i = 4'b0100;
        while (!bus.rng_req_o && w < 20) begin
            step();
            w++;
        end
        checks++;
        if (bus.gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL to_gnt got %b want 0100", bus.gnt_o);
        end
        repeat (TIMEOUT) step();
        checks++;
        if (n_timeout != t0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL to_early timeouts=%0d busy=%b want 0 and 1", n_timeout - t0, bus.busy_o);
        end
        bus.req_i = 4'b0101;
        step();
        checks++;
        if (bus.timeout_o !== 1'b1 || bus.gnt_o !== '0 || bus.busy_o !== 1'b0 || n_ack != a0) begin
            errors++;
            $display("FAIL to_pulse timeout=%b gnt=%b busy=%b acks=%0d want 1 0 0 0",
                     bus.timeout_o, bus.gnt_o, bus.busy_o, n_ack - a0);
        end
        serve(4'b0001, 8'h5A, 1, 1'b0);
        bus.req_i = '0;
        step();
        checks++;
        if (n_timeout - t0 != 1) begin
            errors++;
            $display("FAIL to_count got %0d want 1", n_timeout - t0);
        end
    endtask

    // Reset during WAIT: the transaction is dropped, a late valid is ignored, and ptr returns to 0.
    task automatic test_reset_in_wait();
        int t0, a0, w;
        t0 = n_timeout;
        a0 = n_ack;
        w  = 0;
        bus.req_i = 4'b0100;
        while (!bus.rng_req_o && w < 20) begin
            step();
            w++;
        end
        step();
        rst       = 1'b1;
        bus.req_i = '0;
        step();
        checks++;
        if ({bus.gnt_o, bus.ack_o, bus.rng_req_o, bus.busy_o, bus.timeout_o, bus.data_o} !== '0) begin
            errors++;
            $display("FAIL rw_outputs gnt=%b ack=%b rng_req=%b busy=%b timeout=%b data=%h want all 0",
                     bus.gnt_o, bus.ack_o, bus.rng_req_o, bus.busy_o, bus.timeout_o, bus.data_o);
        end
        rst             = 1'b0;
        last_word       = '0;
        bus.rng_valid_i = 1'b1;
        bus.rng_data_i  = 8'hEE;
        step();
        bus.rng_valid_i = 1'b0;
        repeat (TIMEOUT + 5) step();
        checks++;
        if (n_ack != a0 || n_timeout != t0 || bus.data_o !== 8'h00) begin
            errors++;
            $display("FAIL rw_quiet acks=%0d timeouts=%0d data=%h want 0 0 00",
                     n_ack - a0, n_timeout - t0, bus.data_o);
        end
        bus.req_i = 4'b1111;
        serve(4'b0001, 8'h77, 1, 1'b0);
        bus.req_i = '0;
        step();
    endtask

    // A stray strobe in IDLE is ignored. When the winner drops req_i in WAIT, it is still acked.
    task automatic test_stray();
        int a0;
        a0 = n_ack;
        bus.rng_valid_i = 1'b1;
        bus.rng_data_i  = 8'h3C;
        step();
        bus.rng_valid_i = 1'b0;
        step();
        checks++;
        if (bus.data_o !== last_word || n_ack != a0) begin
            errors++;
            $display("FAIL stray_idle data=%h acks=%0d want %h and 0", bus.data_o, n_ack - a0, last_word);
        end
        bus.req_i = 4'b0010;
        serve(4'b0010, 8'hC3, 2, 1'b1);
        step();
        checks++;
        if (n_ack - a0 != 1) begin
            errors++;
            $display("FAIL drop_ack acks=%0d want 1", n_ack - a0);
        end
    endtask

    // After requester 3 is served, req_i=1010 is granted as 0010 and then 1000.
    task automatic test_wrap();
        bus.req_i = 4'b1000;
        serve(4'b1000, 8'h81, 1, 1'b0);
        bus.req_i = 4'b1010;
        serve(4'b0010, 8'h82, 1, 1'b0);
        serve(4'b1000, 8'h83, 1, 1'b0);
        bus.req_i = '0;
        repeat (3) step();
    endtask

    initial begin
        bus.req_i       = '0;
        bus.rng_valid_i = 1'b0;
        bus.rng_data_i  = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_reset_in_wait();
        test_stray();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain %0d expected acks never seen, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
